mipi_rx_lane_deskew: RTL

MIPI_RX_LANE_DESKEW -- requirements
Module: mipi_rx_lane_deskew

---
 rtl/mipi_rx_lane_deskew.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mipi_rx_lane_deskew.sv
// Per-lane skew compensation for a MIPI receiver: measures lane arrival offsets
// at packet start, then replays every lane from a delay tap so bytes line up.
module mipi_rx_lane_deskew #(
  parameter int unsigned MIPI_LANES = 4,
  parameter int unsigned MAX_SKEW   = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    sync_clear_i,
  input  logic [3:0]              active_lanes_i,
  input  logic [MIPI_LANES-1:0]   bytes_valid_i,
  input  logic [8*MIPI_LANES-1:0] byte_i,
  output logic                    lane_valid_o,
  output logic [8*MIPI_LANES-1:0] lane_byte_o,
  output logic                    skew_error_o,
  output logic [3:0]              lanes_used_o
);

  localparam int unsigned LW = 4;
  localparam int unsigned OW = 4;
  localparam int unsigned CW = 5;
  localparam int unsigned BW = 8 * MIPI_LANES;
  localparam int unsigned TAPS = MAX_SKEW + 1;

  typedef enum logic [1:0] {IDLE, ALIGN, STREAM, ERROR} state_t;

  state_t                state_q, state_nxt;
  logic [CW-1:0]         cnt_q, cnt_nxt;
  logic [MIPI_LANES-1:0] arrived_q, arrived_nxt;
  logic [OW-1:0]         off_q   [MIPI_LANES];
  logic [OW-1:0]         off_nxt [MIPI_LANES];
  logic [LW-1:0]         used_nxt, used_in_c;
  logic                  valid_nxt, err_nxt, clr;
  logic [BW-1:0]         byte_nxt;

  // Tap 0 is the input register; tap t is that register delayed by t cycles.
  logic                  dl_v [MIPI_LANES][TAPS];
  logic [7:0]            dl_b [MIPI_LANES][TAPS];

  logic [MIPI_LANES-1:0] act, vnow, new_arr, sel_v;
  logic [OW-1:0]         eff_off [MIPI_LANES];
  logic [OW-1:0]         tap     [MIPI_LANES];
  logic [7:0]            sel_b   [MIPI_LANES];
  logic [OW-1:0]         maxoff;
  logic                  seek, all_arr, and_v, en;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int k = 0; k < int'(MIPI_LANES); k++) begin
        for (int t = 0; t < int'(TAPS); t++) begin
          dl_v[k][t] <= 1'b0;
          dl_b[k][t] <= 8'h00;
        end
      end
    end else begin
      for (int k = 0; k < int'(MIPI_LANES); k++) begin
        if (sync_clear_i) begin
          for (int t = 0; t < int'(TAPS); t++) begin
            dl_v[k][t] <= 1'b0;
            dl_b[k][t] <= 8'h00;
          end
        end else begin
          dl_v[k][0] <= bytes_valid_i[k];
          dl_b[k][0] <= byte_i[8*k +: 8];
          for (int t = 1; t < int'(TAPS); t++) begin
            dl_v[k][t] <= dl_v[k][t-1];
            dl_b[k][t] <= dl_b[k][t-1];
          end
        end
      end
    end
  end

  assign used_in_c = (active_lanes_i == '0 || active_lanes_i > LW'(MIPI_LANES))
                     ? LW'(MIPI_LANES) : active_lanes_i;

  // Arrival bookkeeping and tap selection; lanes arriving now use the live count.
  always_comb begin
    seek    = (state_q == IDLE) || (state_q == ALIGN);
    act     = '0;
    vnow    = '0;
    new_arr = '0;
    sel_v   = '0;
    maxoff  = '0;
    for (int k = 0; k < int'(MIPI_LANES); k++) begin
      act[k]     = (LW'(k) < lanes_used_o);
      vnow[k]    = dl_v[k][0] & act[k];
      new_arr[k] = vnow[k] & ~arrived_q[k] & seek;
      eff_off[k] = arrived_q[k] ? off_q[k] : OW'(cnt_q);
      if (act[k] && (arrived_q[k] || new_arr[k]) && eff_off[k] > maxoff)
        maxoff = eff_off[k];
    end
    all_arr = &(arrived_q | new_arr | ~act);
    for (int k = 0; k < int'(MIPI_LANES); k++) begin
      tap[k]   = act[k] ? OW'(maxoff - eff_off[k]) : '0;
      sel_b[k] = 8'h00;
      for (int t = 0; t < int'(TAPS); t++) begin
        if (act[k] && tap[k] == OW'(t)) begin
          sel_v[k] = dl_v[k][t];
          sel_b[k] = dl_b[k][t];
        end
      end
    end
    and_v = &(sel_v | ~act);
    en    = (seek && all_arr) || (state_q == STREAM);
  end

  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    arrived_nxt = arrived_q;
    off_nxt     = off_q;
    used_nxt    = lanes_used_o;
    valid_nxt   = 1'b0;
    byte_nxt    = '0;
    err_nxt     = 1'b0;
    clr         = 1'b0;

    for (int k = 0; k < int'(MIPI_LANES); k++) begin
      if (new_arr[k]) begin
        arrived_nxt[k] = 1'b1;
        off_nxt[k]     = OW'(cnt_q);
      end
    end

    if (en) begin
      valid_nxt = and_v;
      for (int k = 0; k < int'(MIPI_LANES); k++) byte_nxt[8*k +: 8] = sel_b[k];
    end

    case (state_q)
      IDLE: begin
        cnt_nxt = '0;
        if (|vnow) begin
          state_nxt = ALIGN;
          cnt_nxt   = CW'(1);
        end else begin
          used_nxt = used_in_c;
        end
      end
      ALIGN: begin
        cnt_nxt = cnt_q + CW'(1);
        if (all_arr) begin
          state_nxt = STREAM;
        end else if (cnt_q == CW'(MAX_SKEW)) begin
          state_nxt = ERROR;
          err_nxt   = 1'b1;
        end
      end
      STREAM: if (!and_v) clr = 1'b1;
      ERROR:  if (!(|vnow)) clr = 1'b1;
      default: clr = 1'b1;
    endcase

    // Line-boundary clear overrides whatever the state machine decided.
    if (clr || sync_clear_i) begin
      state_nxt   = IDLE;
      cnt_nxt     = '0;
      arrived_nxt = '0;
      for (int k = 0; k < int'(MIPI_LANES); k++) off_nxt[k] = '0;
    end
    if (sync_clear_i) begin
      valid_nxt = 1'b0;
      byte_nxt  = '0;
      err_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      arrived_q    <= '0;
      for (int k = 0; k < int'(MIPI_LANES); k++) off_q[k] <= '0;
      lanes_used_o <= LW'(MIPI_LANES);
      lane_valid_o <= 1'b0;
      lane_byte_o  <= '0;
      skew_error_o <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      cnt_q        <= cnt_nxt;
      arrived_q    <= arrived_nxt;
      off_q        <= off_nxt;
      lanes_used_o <= used_nxt;
      lane_valid_o <= valid_nxt;
      lane_byte_o  <= byte_nxt;
      skew_error_o <= err_nxt;
    end
  end

endmodule
